// File: rtl/ucaspian_axon_sched_pkg.sv
// Shared types and default widths for the axon scheduler slice.
package ucaspian_pkg;

    localparam int SYN_ADDR_W = 10;
    localparam int SYN_CNT_W  = 8;

    typedef enum logic {
        SCHED_IDLE,
        SCHED_BURST
    } sched_state_t;

endpackage

// File: rtl/ucaspian_axon_sched_if.sv
// Handshake bundles around the scheduler: axon request side and synapse address side.

// Axon requesters (master) present bursts to the scheduler (slave).
interface ucaspian_req_if
    import ucaspian_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SYN_ADDR_W,
    parameter int CNT_W   = SYN_CNT_W
) ();
    logic [NUM_REQ*ADDR_W-1:0] req_start;
    logic [NUM_REQ*CNT_W-1:0]  req_count;
    logic [NUM_REQ-1:0]        req_vld;
    logic [NUM_REQ-1:0]        req_rdy;

    modport master (output req_start, output req_count, output req_vld, input  req_rdy);
    modport slave  (input  req_start, input  req_count, input  req_vld, output req_rdy);
endinterface

// Scheduler (master) streams synapse addresses into the synapse unit (slave).
interface ucaspian_syn_if
    import ucaspian_pkg::*;
#(
    parameter int ADDR_W = SYN_ADDR_W
) ();
    logic [ADDR_W-1:0] syn_addr;
    logic              syn_vld;
    logic              syn_rdy;

    modport master (output syn_addr, output syn_vld, input  syn_rdy);
    modport slave  (input  syn_addr, input  syn_vld, output syn_rdy);
endinterface

// File: rtl/ucaspian_axon_sched_rr_arbiter.sv
// Round-robin pick among requesters, starting just after the last winner.
// Purely combinational; the pointer register lives in the parent.
module ucaspian_rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    // Scan ptr+1 .. ptr+NUM_REQ with wrap; first set request wins.
    always_comb begin
        logic found;
        int   idx;
        found       = 1'b0;
        idx         = 0;
        grant_o     = '0;
        grant_idx_o = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = (int'(ptr_i) + off) % NUM_REQ;
            if (en_i && !found && req_i[idx]) begin
                found        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ucaspian_axon_sched.sv
// Shares one synapse unit between NUM_REQ axon requesters: grants one
// fan-out burst at a time and streams its addresses, one per handshake.
//
// state        | meaning
// SCHED_IDLE   | no burst in flight; arbiter may grant a waiting requester
// SCHED_BURST  | streaming addresses of the granted burst to the synapse unit
module ucaspian_axon_sched
    import ucaspian_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = SYN_ADDR_W,
    parameter int CNT_W   = SYN_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable_i,
    input  logic               clear_act_i,
    output logic               clear_done_o,
    output logic               step_done_o,
    ucaspian_req_if.slave      req_if,
    ucaspian_syn_if.master     syn_if
);

    localparam int IDX_W = $clog2(NUM_REQ);

    sched_state_t      state_q;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [ADDR_W-1:0] cur_addr_q;
    logic [CNT_W-1:0]  remaining_q;
    logic              syn_vld_q;
    logic              clear_done_q;
    logic              step_done_q;

    logic              arb_en;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              accept;
    logic              hs;
    logic [ADDR_W-1:0] win_start;
    logic [CNT_W-1:0]  win_count;

    // Grants only from idle, and never while an abort is being applied.
    assign arb_en = (state_q == SCHED_IDLE) && enable_i && !clear_act_i;

    ucaspian_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i       (req_if.req_vld),
        .ptr_i       (rr_ptr_q),
        .en_i        (arb_en),
        .grant_o     (grant),
        .grant_idx_o (grant_idx)
    );

    assign req_if.req_rdy = grant;
    assign accept         = |(grant & req_if.req_vld);
    assign win_start      = req_if.req_start[int'(grant_idx)*ADDR_W +: ADDR_W];
    assign win_count      = req_if.req_count[int'(grant_idx)*CNT_W +: CNT_W];
    assign hs             = syn_vld_q && syn_if.syn_rdy;

    assign syn_if.syn_addr = cur_addr_q;
    assign syn_if.syn_vld  = syn_vld_q;
    assign clear_done_o    = clear_done_q;
    assign step_done_o     = step_done_q;

    // Scheduler FSM with registered synapse-side outputs and status flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SCHED_IDLE;
            rr_ptr_q     <= IDX_W'(NUM_REQ - 1);
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            syn_vld_q    <= 1'b0;
            clear_done_q <= 1'b0;
            step_done_q  <= 1'b0;
        end else begin
            step_done_q  <= (state_q == SCHED_IDLE) && !syn_vld_q && !(|req_if.req_vld);
            clear_done_q <= clear_act_i;
            if (clear_act_i) begin
                // Abort drops the burst silently; the arbitration pointer is kept.
                state_q     <= SCHED_IDLE;
                syn_vld_q   <= 1'b0;
                remaining_q <= '0;
            end else begin
                case (state_q)
                    SCHED_IDLE: begin
                        if (accept) begin
                            rr_ptr_q <= grant_idx;
                            // Zero-length bursts are consumed without touching the synapse port.
                            if (win_count != '0) begin
                                cur_addr_q  <= win_start;
                                remaining_q <= win_count;
                                syn_vld_q   <= 1'b1;
                                state_q     <= SCHED_BURST;
                            end
                        end
                    end
                    SCHED_BURST: begin
                        if (hs) begin
                            cur_addr_q  <= cur_addr_q + ADDR_W'(1);
                            remaining_q <= remaining_q - CNT_W'(1);
                            if (remaining_q == CNT_W'(1)) begin
                                syn_vld_q <= 1'b0;
                                state_q   <= SCHED_IDLE;
                            end
                        end
                    end
                    default: begin
                        state_q   <= SCHED_IDLE;
                        syn_vld_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ucaspian_axon_sched.sv
// Directed bench for the axon scheduler: grant order, address streams,
// backpressure, zero-length bursts, enable gating, abort and reset.
module tb_ucaspian_axon_sched;

    localparam int NR = 4;
    localparam int AW = 10;
    localparam int CW = 8;

    logic clk;
    logic reset;
    logic enable;
    logic clear_act;
    logic clear_done;
    logic step_done;

    ucaspian_req_if #(.NUM_REQ(NR), .ADDR_W(AW), .CNT_W(CW)) req_bus ();
    ucaspian_syn_if #(.ADDR_W(AW)) syn_bus ();

    ucaspian_axon_sched #(
        .NUM_REQ (NR),
        .ADDR_W  (AW),
        .CNT_W   (CW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .clear_act_i  (clear_act),
        .clear_done_o (clear_done),
        .step_done_o  (step_done),
        .req_if       (req_bus),
        .syn_if       (syn_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int c0;
    int g_log[$];
    int hs_addr[$];
    int hs_cyc[$];
    logic [NR-1:0] drop_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic chk_seq(input string tag, input int q[$], input int exp[$]);
        chk({tag, ".len"}, q.size(), exp.size());
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), qget(q, i), exp[i]);
    endtask

    task automatic clr_logs();
        g_log.delete();
        hs_addr.delete();
        hs_cyc.delete();
        c0 = cyc;
    endtask

    task automatic set_req(input int i, input int start, input int cnt);
        req_bus.req_start[i*AW +: AW] = AW'(start);
        req_bus.req_count[i*CW +: CW] = CW'(cnt);
    endtask

    // One clock: record grants/handshakes at negedge, then retire accepted requests.
    task automatic tick();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = req_bus.req_vld & req_bus.req_rdy;
        for (int i = 0; i < NR; i++)
            if (acc[i]) g_log.push_back(i);
        if (syn_bus.syn_vld && syn_bus.syn_rdy && !clear_act) begin
            hs_addr.push_back(int'(syn_bus.syn_addr));
            hs_cyc.push_back(cyc - c0);
        end
        @(posedge clk);
        #1;
        cyc++;
        req_bus.req_vld = req_bus.req_vld & ~(acc & drop_mask);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset             = 1'b0;
        enable            = 1'b1;
        clear_act         = 1'b0;
        syn_bus.syn_rdy   = 1'b1;
        req_bus.req_start = '0;
        req_bus.req_count = '0;
        req_bus.req_vld   = '0;
        drop_mask         = '1;
        @(posedge clk);
        #1;
        clr_logs();

        // Reset state
        run(2);
        chk("rst.syn_vld", syn_bus.syn_vld, 0);
        chk("rst.syn_addr", syn_bus.syn_addr, 0);
        chk("rst.clear_done", clear_done, 0);
        chk("rst.step_done", step_done, 0);
        chk("rst.req_rdy", req_bus.req_rdy, 0);
        reset = 1'b1;
        run(2);
        chk("idle.step_done", step_done, 1);

        // Single request: 5,6,7 on consecutive cycles one cycle after accept
        clr_logs();
        set_req(0, 5, 3);
        req_bus.req_vld[0] = 1'b1;
        #1;
        chk("single.req_rdy", req_bus.req_rdy, 4'b0001);
        run(6);
        chk_seq("single.addr", hs_addr, '{5, 6, 7});
        chk_seq("single.cyc", hs_cyc, '{1, 2, 3});
        chk_seq("single.grant", g_log, '{0});
        chk("single.syn_vld", syn_bus.syn_vld, 0);
        chk("single.step_done", step_done, 1);

        // Address wrap at 1023
        clr_logs();
        set_req(0, 1022, 4);
        req_bus.req_vld[0] = 1'b1;
        run(7);
        chk_seq("wrap.addr", hs_addr, '{1022, 1023, 0, 1});

        // Round robin from a fresh pointer; req1 joins after four grants
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        clr_logs();
        drop_mask = 4'b1010;
        set_req(0, 10, 1);
        set_req(1, 20, 1);
        set_req(2, 30, 1);
        req_bus.req_vld = 4'b0101;
        run(7);
        req_bus.req_vld[1] = 1'b1;
        run(7);
        req_bus.req_vld = '0;
        run(2);
        drop_mask = '1;
        chk_seq("rr.grant", g_log, '{0, 2, 0, 2, 0, 1, 2});
        chk_seq("rr.addr", hs_addr, '{10, 30, 10, 30, 10, 20, 30});

        // Backpressure: syn_rdy low for the first three valid cycles
        clr_logs();
        set_req(0, 40, 2);
        req_bus.req_vld[0] = 1'b1;
        syn_bus.syn_rdy = 1'b0;
        tick();
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("bp.vld%0d", k), syn_bus.syn_vld, 1);
            chk($sformatf("bp.addr%0d", k), syn_bus.syn_addr, 40);
            tick();
        end
        syn_bus.syn_rdy = 1'b1;
        run(3);
        chk_seq("bp.addr", hs_addr, '{40, 41});
        chk_seq("bp.cyc", hs_cyc, '{4, 5});

        // Zero-length burst is accepted but never reaches the synapse port
        clr_logs();
        set_req(3, 77, 0);
        req_bus.req_vld[3] = 1'b1;
        #1;
        chk("zero.req_rdy", req_bus.req_rdy, 4'b1000);
        run(4);
        chk_seq("zero.grant", g_log, '{3});
        chk("zero.hs_len", hs_addr.size(), 0);
        chk("zero.step_done", step_done, 1);

        // enable low holds off grants; grant follows the enable rise
        clr_logs();
        enable = 1'b0;
        set_req(1, 200, 1);
        req_bus.req_vld[1] = 1'b1;
        #1;
        chk("en0.req_rdy", req_bus.req_rdy, 0);
        run(3);
        chk("en0.grant_len", g_log.size(), 0);
        chk("en0.step_done", step_done, 0);
        enable = 1'b1;
        #1;
        chk("en1.req_rdy", req_bus.req_rdy, 4'b0010);
        run(3);
        chk_seq("en1.grant", g_log, '{1});
        chk_seq("en1.addr", hs_addr, '{200});

        // Abort after three handshakes of a 10-long burst
        clr_logs();
        set_req(0, 100, 10);
        req_bus.req_vld[0] = 1'b1;
        run(4);
        chk("abort.pre_vld", syn_bus.syn_vld, 1);
        clear_act = 1'b1;
        syn_bus.syn_rdy = 1'b0;
        tick();
        clear_act = 1'b0;
        syn_bus.syn_rdy = 1'b1;
        chk("abort.syn_vld", syn_bus.syn_vld, 0);
        chk("abort.clear_done", clear_done, 1);
        tick();
        chk("abort.clear_done_fall", clear_done, 0);
        chk("abort.step_done", step_done, 1);
        chk_seq("abort.addr", hs_addr, '{100, 101, 102});

        // clear_act blocks a grant; pointer survives the abort (last winner 0)
        set_req(0, 300, 1);
        set_req(1, 310, 1);
        req_bus.req_vld = 4'b0011;
        clear_act = 1'b1;
        #1;
        chk("clr.req_rdy", req_bus.req_rdy, 0);
        tick();
        clear_act = 1'b0;
        #1;
        chk("clr.ptr_rdy", req_bus.req_rdy, 4'b0010);
        clr_logs();
        run(5);
        chk_seq("clr.grant", g_log, '{1, 0});
        chk_seq("clr.addr", hs_addr, '{310, 300});

        // Reset mid-burst clears outputs and restores the pointer to NUM_REQ-1
        clr_logs();
        set_req(2, 500, 10);
        req_bus.req_vld[2] = 1'b1;
        run(3);
        reset = 1'b0;
        tick();
        chk("mrst.syn_vld", syn_bus.syn_vld, 0);
        chk("mrst.syn_addr", syn_bus.syn_addr, 0);
        chk("mrst.clear_done", clear_done, 0);
        chk("mrst.step_done", step_done, 0);
        reset = 1'b1;
        set_req(0, 600, 1);
        set_req(3, 700, 1);
        req_bus.req_vld = 4'b1001;
        #1;
        chk("mrst.req_rdy", req_bus.req_rdy, 4'b0001);
        clr_logs();
        run(6);
        chk_seq("mrst.grant", g_log, '{0, 3});
        chk_seq("mrst.addr", hs_addr, '{600, 700});

        req_bus.req_vld = '0;
        run(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ucaspian_axon_sched.md
Name: ucaspian_axon_sched

Overview:
Scheduler that shares one synapse unit between NUM_REQ axon requesters. Each requester fires a fan-out burst, given as a start synapse address and a synapse count. The winning burst is streamed into the synapse unit's syn_addr/syn_vld/syn_rdy port, one address per handshake. The block sits between the axon units and the synapse unit, and reports idle status to the time-step sync logic.

Parameters:
NUM_REQ, 4, number of axon requesters (2..8)
ADDR_W, 10, synapse address width (1024 synapses per unit)
CNT_W, 8, burst-length width (0..255 synapses per fire)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
enable  in  1  permit new grants
clear_act  in  1  abort activity, return to idle
clear_done  out  1  clear complete
step_done  out  1  no pending or in-flight work (registered)
req_start  in  NUM_REQ*ADDR_W  per-requester start address; slot i = bits [i*ADDR_W +: ADDR_W]
req_count  in  NUM_REQ*CNT_W  per-requester burst length
req_vld  in  NUM_REQ  request valid
req_rdy  out  NUM_REQ  request accepted (one-hot, combinational)
syn_addr  out  ADDR_W  synapse address to synapse unit
syn_vld  out  1  address valid
syn_rdy  in  1  synapse unit ready

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; syn_vld=0, syn_addr=0, clear_done=0, step_done=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority first.
- States: IDLE, BURST.
- IDLE:
  - If enable && !clear_act && any req_vld: winner = first requester with req_vld set, scanning from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - req_rdy[winner]=1 combinationally in that cycle; all other req_rdy bits 0. Acceptance = req_vld[i] && req_rdy[i].
  - On acceptance, rr_ptr<=winner.
  - If count==0: drop the request and stay in IDLE. No syn_vld is issued.
  - Otherwise: cur_addr<=start, remaining<=count, syn_addr<=start, syn_vld<=1, go to BURST.
  - First syn_vld appears 1 cycle after acceptance.
- BURST:
  - req_rdy all 0.
  - syn_addr and syn_vld are held stable until syn_vld && syn_rdy.
  - On each handshake: cur_addr<=cur_addr+1 mod 2^ADDR_W (1023 wraps to 0); remaining<=remaining-1.
  - If remaining==1 at the handshake: syn_vld<=0, go to IDLE. A new grant is possible in the next cycle.
  - Back-to-back handshakes are allowed, up to 1 address/cycle when syn_rdy is held high.
- enable=0: blocks new grants only. A burst in progress completes.
- clear_act:
  - Highest priority after reset: state<=IDLE, syn_vld<=0, remaining<=0, req_rdy forced 0.
  - rr_ptr is preserved.
  - clear_done<=1 on each cycle clear_act is sampled high; otherwise 0.
  - The aborted burst is lost; the requester is not notified.
- step_done <= (state==IDLE) && !syn_vld && !(|req_vld), registered each cycle.
- Simultaneous events:
  - clear_act wins over a request accept and over a syn handshake in the same cycle.
  - A requester deasserting req_vld is legal only when not accepted.
- Widths: remaining is CNT_W bits. Address arithmetic is ADDR_W bits, unsigned, with natural wrap.

Decomposition:
- Package ucaspian_pkg: SYN_ADDR_W=10, SYN_CNT_W=8, typedef enum logic {SCHED_IDLE, SCHED_BURST} sched_state_t.
- Sub-module ucaspian_rr_arbiter: parameter NUM_REQ; inputs req, ptr, en; output one-hot grant plus grant index. Purely combinational; the pointer register lives in the parent.

Test Plan:
- Single request: req0 start=5, count=3, syn_rdy=1 -> req_rdy[0] pulses once; syn_addr 5,6,7 on 3 consecutive cycles starting 1 cycle later; then syn_vld=0 and step_done=1.
- Wrap-around: start=1022, count=4 -> syn_addr sequence 1022,1023,0,1.
- Round robin: req0 and req2 held valid, each count=1 -> grant order 0,2,0,2. Add req1 mid-stream -> order continues 2,0,1,2 per the pointer.
- Backpressure: start=40, count=2; syn_rdy low 3 cycles after the first valid -> syn_addr stays 40 and syn_vld stays 1; then 41 follows. Matches the synapse unit's 1-accept-per-4-cycles pacing.
- Zero count and enable: count=0 -> accepted, no syn_vld ever. enable=0 with req pending -> no req_rdy; grant follows the enable rise.
- Abort: clear_act for 1 cycle mid-burst (start=100, count=10, after 3 handshakes) -> next cycle syn_vld=0, clear_done=1, state IDLE. reset=0 mid-burst -> all outputs 0 and rr_ptr=NUM_REQ-1.
